// File: rtl/io_device_mux.sv
// io_device_mux: decodes the bridge's registered I/O bus into NDEV device slots.
// Ports: s_* carry the bridge-side slave bus (ack/err/data returned to the bridge).
// d_* drive the devices: one-hot chip select, shared strobes, address and write data.
// d_ack_i and d_dat_i are the per-device returns; slot k occupies d_dat_i[32k+31:32k].
module io_device_mux #(
  parameter int unsigned  NDEV     = 8,
  parameter logic [11:0]  IO_PAGE  = 12'hFD0,
  parameter int unsigned  SLOT_LSB = 16,
  parameter int unsigned  TIMEOUT  = 16,
  parameter logic [31:0]  ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 rst_i,
  input  logic                 clk_i,
  input  logic                 s_cyc_i,
  input  logic                 s_stb_i,
  input  logic                 s_we_i,
  input  logic [3:0]           s_sel_i,
  input  logic [31:0]          s_adr_i,
  input  logic [31:0]          s_dat_i,
  output logic                 s_ack_o,
  output logic                 s_err_o,
  output logic [31:0]          s_dat_o,
  output logic [NDEV-1:0]      d_cs_o,
  output logic                 d_cyc_o,
  output logic                 d_stb_o,
  output logic                 d_we_o,
  output logic [3:0]           d_sel_o,
  output logic [31:0]          d_adr_o,
  output logic [31:0]          d_dat_o,
  input  logic [NDEV-1:0]      d_ack_i,
  input  logic [NDEV*32-1:0]   d_dat_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        slot_q, slot_d;

  logic [NDEV-1:0]   cs_d;
  logic              cyc_d, stb_d, we_d;
  logic [3:0]        sel_d;
  logic [31:0]       adr_d, wdat_d;
  logic              ack_d, err_d;
  logic [31:0]       rdat_d;

  logic              req;
  logic [3:0]        req_slot;
  logic              dec_ok;
  logic [NDEV-1:0]   req_cs;
  logic              sel_ack;
  logic [31:0]       sel_rdat;

  assign req      = s_cyc_i & s_stb_i & ~|d_ack_i;
  assign req_slot = s_adr_i[SLOT_LSB +: 4];
  assign dec_ok   = (s_adr_i[31:20] == IO_PAGE) && ({1'b0, req_slot} < 5'(NDEV));

  // Loop-based select keeps indices in range for any NDEV below 16.
  always_comb begin
    req_cs   = '0;
    sel_ack  = 1'b0;
    sel_rdat = '0;
    for (int unsigned k = 0; k < NDEV; k++) begin
      req_cs[k] = (req_slot == k[3:0]);
      if (slot_q == k[3:0]) begin
        sel_ack  = d_ack_i[k];
        sel_rdat = d_dat_i[k*32 +: 32];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      d_cs_o  <= '0;
      d_cyc_o <= 1'b0;
      d_stb_o <= 1'b0;
      d_we_o  <= 1'b0;
      d_sel_o <= '0;
      d_adr_o <= '0;
      d_dat_o <= '0;
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      s_dat_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      d_cs_o  <= cs_d;
      d_cyc_o <= cyc_d;
      d_stb_o <= stb_d;
      d_we_o  <= we_d;
      d_sel_o <= sel_d;
      d_adr_o <= adr_d;
      d_dat_o <= wdat_d;
      s_ack_o <= ack_d;
      s_err_o <= err_d;
      s_dat_o <= rdat_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = dec_ok ? ACTIVE : RESP;
      end
      ACTIVE: begin
        if (sel_ack)                 state_d = RESP;
        else if (!s_stb_i)           state_d = IDLE;
        else if (cnt_q == TO_LAST)   state_d = RESP;
      end
      RESP: begin
        if (!s_stb_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs
  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    cs_d   = d_cs_o;
    cyc_d  = d_cyc_o;
    stb_d  = d_stb_o;
    we_d   = d_we_o;
    sel_d  = d_sel_o;
    adr_d  = d_adr_o;
    wdat_d = d_dat_o;
    ack_d  = s_ack_o;
    err_d  = s_err_o;
    rdat_d = s_dat_o;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          slot_d = req_slot;
          cnt_d  = '0;
          if (dec_ok) begin
            cs_d   = req_cs;
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            we_d   = s_we_i;
            sel_d  = s_sel_i;
            adr_d  = s_adr_i;
            wdat_d = s_dat_i;
          end else begin
            ack_d  = 1'b1;
            err_d  = 1'b1;
            rdat_d = ERR_DATA;
          end
        end
      end
      ACTIVE: begin
        if (sel_ack || !s_stb_i || cnt_q == TO_LAST) begin
          cs_d   = '0;
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          we_d   = 1'b0;
          sel_d  = '0;
          adr_d  = '0;
          wdat_d = '0;
        end
        if (sel_ack) begin
          ack_d  = 1'b1;
          err_d  = 1'b0;
          rdat_d = sel_rdat;
        end else if (s_stb_i && cnt_q == TO_LAST) begin
          ack_d  = 1'b1;
          err_d  = 1'b1;
          rdat_d = ERR_DATA;
        end else if (s_stb_i && cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (!s_stb_i) begin
          ack_d  = 1'b0;
          err_d  = 1'b0;
          rdat_d = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_device_mux.sv
module tb_io_device_mux;

  localparam int unsigned NDEV = 8;

  logic              rst_i, clk_i;
  logic              s_cyc_i, s_stb_i, s_we_i;
  logic [3:0]        s_sel_i;
  logic [31:0]       s_adr_i, s_dat_i;
  logic              s_ack_o, s_err_o;
  logic [31:0]       s_dat_o;
  logic [NDEV-1:0]   d_cs_o;
  logic              d_cyc_o, d_stb_o, d_we_o;
  logic [3:0]        d_sel_o;
  logic [31:0]       d_adr_o, d_dat_o;
  logic [NDEV-1:0]   d_ack_i;
  logic [NDEV*32-1:0] d_dat_i;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  int unsigned hi;

  io_device_mux #(
    .NDEV(NDEV),
    .IO_PAGE(12'hFD0),
    .SLOT_LSB(16),
    .TIMEOUT(16),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .rst_i(rst_i), .clk_i(clk_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_dat_o(s_dat_o),
    .d_cs_o(d_cs_o), .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o), .d_we_o(d_we_o),
    .d_sel_o(d_sel_o), .d_adr_o(d_adr_o), .d_dat_o(d_dat_o),
    .d_ack_i(d_ack_i), .d_dat_i(d_dat_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                     input logic [31:0] dat);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_sel_i = sel;
    s_adr_i = adr;  s_dat_i = dat;
  endtask

  task automatic drop();
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  task automatic set_slot(input int k, input logic [31:0] v);
    d_dat_i[k*32 +: 32] = v;
  endtask

  initial begin
    rst_i = 1'b1; s_cyc_i = 0; s_stb_i = 0; s_we_i = 0; s_sel_i = '0;
    s_adr_i = '0; s_dat_i = '0; d_ack_i = '0; d_dat_i = '0;
    tick(); tick(); tick();
    rst_i = 1'b0;
    tick();
    check("rst_ack", 32'(s_ack_o), 32'd0);
    check("rst_stb", 32'(d_stb_o), 32'd0);
    check("rst_cs",  32'(d_cs_o),  32'd0);
    check("rst_dat", s_dat_o,      32'd0);

    // Read slot 3, device acks two cycles after strobe
    req(32'hFD03_0010, 1'b0, 4'hF, 32'h0);
    tick();
    check("rd_stb", 32'(d_stb_o), 32'd1);
    check("rd_cs",  32'(d_cs_o),  32'h08);
    check("rd_adr", d_adr_o,      32'hFD03_0010);
    tick();
    check("rd_noack_early", 32'(s_ack_o), 32'd0);
    d_ack_i = 8'h08; set_slot(3, 32'h1234_5678);
    tick();
    d_ack_i = '0;
    check("rd_ack", 32'(s_ack_o), 32'd1);
    check("rd_err", 32'(s_err_o), 32'd0);
    check("rd_dat", s_dat_o,      32'h1234_5678);
    check("rd_stb_clr", 32'(d_stb_o), 32'd0);
    tick();
    check("rd_ack_hold", 32'(s_ack_o), 32'd1);
    drop();
    tick();
    check("rd_ack_clr", 32'(s_ack_o), 32'd0);
    check("rd_dat_clr", s_dat_o,      32'd0);

    // Write slot 0
    req(32'hFD00_0040, 1'b1, 4'h3, 32'hA5A5_A5A5);
    tick();
    check("wr_we",  32'(d_we_o),  32'd1);
    check("wr_dat", d_dat_o,      32'hA5A5_A5A5);
    check("wr_sel", 32'(d_sel_o), 32'h3);
    check("wr_cs",  32'(d_cs_o),  32'h01);
    d_ack_i = 8'h01; set_slot(0, 32'h0BAD_F00D);
    tick();
    d_ack_i = '0;
    check("wr_ack", 32'(s_ack_o), 32'd1);
    check("wr_err", 32'(s_err_o), 32'd0);
    check("wr_rdcap", s_dat_o,    32'h0BAD_F00D);
    drop();
    tick();
    check("wr_ack_clr", 32'(s_ack_o), 32'd0);

    // Unmapped: slot beyond NDEV, then wrong page
    req(32'hFD0A_0000, 1'b0, 4'hF, 32'h0);
    tick();
    check("um1_ack", 32'(s_ack_o), 32'd1);
    check("um1_err", 32'(s_err_o), 32'd1);
    check("um1_dat", s_dat_o,      32'hDEAD_BEEF);
    check("um1_stb", 32'(d_stb_o), 32'd0);
    drop();
    tick();
    check("um1_clr", 32'(s_err_o), 32'd0);
    req(32'hFE00_0000, 1'b0, 4'hF, 32'h0);
    tick();
    check("um2_ack", 32'(s_ack_o), 32'd1);
    check("um2_err", 32'(s_err_o), 32'd1);
    check("um2_stb", 32'(d_stb_o), 32'd0);
    drop();
    tick();

    // Timeout on slot 5
    req(32'hFD05_0000, 1'b0, 4'hF, 32'h0);
    tick();
    hi = 0;
    for (int i = 0; i < 40 && d_stb_o; i++) begin
      hi++;
      tick();
    end
    check("to_stb_cycles", hi, 32'd16);
    check("to_ack", 32'(s_ack_o), 32'd1);
    check("to_err", 32'(s_err_o), 32'd1);
    check("to_dat", s_dat_o,      32'hDEAD_BEEF);
    d_ack_i = 8'h20; set_slot(5, 32'h5A5A_5A5A);
    tick();
    d_ack_i = '0;
    check("to_late_err", 32'(s_err_o), 32'd1);
    check("to_late_dat", s_dat_o,      32'hDEAD_BEEF);
    drop();
    tick();
    check("to_clr", 32'(s_ack_o), 32'd0);

    // Ack on the same cycle as the timeout condition wins
    req(32'hFD05_0000, 1'b0, 4'hF, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("tob_stb", 32'(d_stb_o), 32'd1);
    d_ack_i = 8'h20; set_slot(5, 32'h5555_5555);
    tick();
    d_ack_i = '0;
    check("tob_ack", 32'(s_ack_o), 32'd1);
    check("tob_err", 32'(s_err_o), 32'd0);
    check("tob_dat", s_dat_o,      32'h5555_5555);
    drop();
    tick();

    // Abort with stray ack from slot 2 while slot 6 selected
    req(32'hFD06_0000, 1'b0, 4'hF, 32'h0);
    tick();
    check("ab_cs", 32'(d_cs_o), 32'h40);
    d_ack_i = 8'h04;
    tick();
    d_ack_i = '0;
    check("ab_stray_ack", 32'(s_ack_o), 32'd0);
    check("ab_stray_stb", 32'(d_stb_o), 32'd1);
    tick();
    s_stb_i = 1'b0;
    tick();
    check("ab_stb", 32'(d_stb_o), 32'd0);
    check("ab_cs_clr", 32'(d_cs_o), 32'd0);
    check("ab_ack", 32'(s_ack_o), 32'd0);
    tick();
    check("ab_ack2", 32'(s_ack_o), 32'd0);
    s_cyc_i = 1'b0;
    tick();

    // Ack coinciding with strobe drop completes normally, then exits
    req(32'hFD07_0000, 1'b0, 4'hF, 32'h0);
    tick();
    d_ack_i = 8'h80; set_slot(7, 32'h7777_0007);
    drop();
    tick();
    d_ack_i = '0;
    check("sd_ack", 32'(s_ack_o), 32'd1);
    check("sd_dat", s_dat_o,      32'h7777_0007);
    tick();
    check("sd_clr", 32'(s_ack_o), 32'd0);

    // Reset mid-ACTIVE
    req(32'hFD04_0000, 1'b1, 4'hF, 32'hCAFE_0004);
    tick();
    check("rs_stb_pre", 32'(d_stb_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drop();
    check("rs_stb", 32'(d_stb_o), 32'd0);
    check("rs_cs",  32'(d_cs_o),  32'd0);
    check("rs_adr", d_adr_o,      32'd0);
    check("rs_ack", 32'(s_ack_o), 32'd0);
    tick();
    check("rs_ack2", 32'(s_ack_o), 32'd0);

    // Back-to-back reads on slots 1 and 2
    req(32'hFD01_0000, 1'b0, 4'hF, 32'h0);
    tick();
    d_ack_i = 8'h02; set_slot(1, 32'h1111_1111);
    tick();
    d_ack_i = '0;
    check("bb1_ack", 32'(s_ack_o), 32'd1);
    check("bb1_dat", s_dat_o,      32'h1111_1111);
    drop();
    tick();
    check("bb_gap", 32'(s_ack_o), 32'd0);
    req(32'hFD02_0000, 1'b0, 4'hF, 32'h0);
    tick();
    check("bb2_cs",  32'(d_cs_o),  32'h04);
    check("bb2_gap", 32'(s_ack_o), 32'd0);
    d_ack_i = 8'h04; set_slot(2, 32'h2222_2222);
    tick();
    d_ack_i = '0;
    check("bb2_ack", 32'(s_ack_o), 32'd1);
    check("bb2_dat", s_dat_o,      32'h2222_2222);
    drop();
    tick();
    check("bb2_clr", 32'(s_ack_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
